// File: rtl/top_pkg.sv
// Shared timing constants, FSM state types and the hex-to-segment decoder.
package top_pkg;

  localparam int unsigned BAUD_DIV     = 868;
  localparam int unsigned BAUD_HALF    = 434;
  localparam int unsigned PS2_TIMEOUT  = 5000;
  localparam int unsigned DIGIT_PERIOD = 16384;

  localparam int unsigned PIX_DIV   = 4;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;
  typedef enum logic       {TX_IDLE, TX_RUN} uart_tx_state_t;

  // Active-high segment pattern, bit order g..a.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_seg = 7'h3F;
      4'h1:    hex_seg = 7'h06;
      4'h2:    hex_seg = 7'h5B;
      4'h3:    hex_seg = 7'h4F;
      4'h4:    hex_seg = 7'h66;
      4'h5:    hex_seg = 7'h6D;
      4'h6:    hex_seg = 7'h7D;
      4'h7:    hex_seg = 7'h07;
      4'h8:    hex_seg = 7'h7F;
      4'h9:    hex_seg = 7'h6F;
      4'hA:    hex_seg = 7'h77;
      4'hB:    hex_seg = 7'h7C;
      4'hC:    hex_seg = 7'h39;
      4'hD:    hex_seg = 7'h5E;
      4'hE:    hex_seg = 7'h79;
      default: hex_seg = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizer, falling-edge sampling, frame check, idle timeout.
module ps2_rx
  import top_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       halt
);

  localparam int unsigned IDLE_W = $clog2(PS2_TIMEOUT);

  logic [1:0]        clk_sync;
  logic [1:0]        data_sync;
  logic              clk_prev;
  logic              fall_c;
  logic              ok_c;
  logic [3:0]        bit_cnt;
  logic [9:0]        shift;
  logic [10:0]       frame_c;
  logic [IDLE_W-1:0] idle_cnt;

  assign fall_c  = clk_prev & ~clk_sync[1];
  assign frame_c = {data_sync[1], shift};
  assign ok_c    = ~frame_c[0] & (^frame_c[9:1]) & frame_c[10];

  // Two-flop synchronizers and edge history; lines idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  // Shift bits on each falling edge; check the 11th bit; abandon stalled frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      shift    <= '0;
      idle_cnt <= '0;
      code     <= '0;
      halt     <= 1'b0;
    end else if (fall_c) begin
      idle_cnt <= '0;
      if (bit_cnt == 4'd10) begin
        bit_cnt <= '0;
        if (ok_c) code <= frame_c[8:1];
        else      halt <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        shift   <= frame_c[10:1];
      end
    end else if (bit_cnt != 4'd0) begin
      if (idle_cnt == IDLE_W'(PS2_TIMEOUT - 1)) begin
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

endmodule

// File: rtl/top.sv
// Keyboard/UART echo board top: PS/2 rx, UART rx/echo tx, hex display scan, VGA pattern.
module top
  import top_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = DIGIT_PERIOD
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] switch_i,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  input  logic        uart_rxd_i,
  output logic        uart_txd_o,
  output logic        halt_o,
  output logic [7:0]  dsp_anode_o,
  output logic [7:0]  dsp_cathode_o,
  output logic [3:0]  vga_red_o,
  output logic [3:0]  vga_green_o,
  output logic [3:0]  vga_blue_o,
  output logic        vga_hsync_o,
  output logic        vga_vsync_o
);

  localparam int unsigned DIG_W  = $clog2(DIGIT_CYCLES);
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);

  logic [15:0]       sw_meta;
  logic [15:0]       sw_s;
  logic [1:0]        rxd_sync;
  logic              rxd_s;
  logic              rxd_prev;
  logic [7:0]        ps2_code;
  logic [7:0]        uart_code;

  uart_rx_state_t    rx_state;
  logic [BAUD_W-1:0] rx_cnt;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_shift;
  logic              rx_fire_c;

  uart_tx_state_t    tx_state;
  logic [BAUD_W-1:0] tx_cnt;
  logic [3:0]        tx_bit;
  logic [8:0]        tx_shift;
  logic              buf_valid;
  logic [7:0]        buf_data;
  logic              tx_end_c;
  logic              tx_free_c;

  logic [DIG_W-1:0]  dig_cnt;
  logic [2:0]        dig;
  logic [3:0]        nib_c;

  logic [1:0]        pix_cnt;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;

  assign rxd_s = rxd_sync[1];

  // Switch and UART rx synchronizers.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sw_meta  <= '0;
      sw_s     <= '0;
      rxd_sync <= 2'b11;
      rxd_prev <= 1'b1;
    end else begin
      sw_meta  <= switch_i;
      sw_s     <= sw_meta;
      rxd_sync <= {rxd_sync[0], uart_rxd_i};
      rxd_prev <= rxd_s;
    end
  end

  ps2_rx u_ps2_rx (
    .clk      (sys_clk_i),
    .rst_n    (rst_n_i),
    .ps2_clk  (ps2_clk_i),
    .ps2_data (ps2_data_i),
    .code     (ps2_code),
    .halt     (halt_o)
  );

  assign rx_fire_c = (rx_state == RX_STOP) && (rx_cnt == BAUD_W'(BAUD_DIV - 1)) && rxd_s;

  // UART receiver: mid-bit sampling from the start-bit falling edge.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      uart_code <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_s) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == BAUD_W'(BAUD_HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + BAUD_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BAUD_W'(BAUD_DIV - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + BAUD_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BAUD_W'(BAUD_DIV - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rxd_s) uart_code <= rx_shift;
          end else begin
            rx_cnt <= rx_cnt + BAUD_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign tx_end_c  = (tx_state == TX_RUN) && (tx_cnt == BAUD_W'(BAUD_DIV - 1)) && (tx_bit == 4'd9);
  assign tx_free_c = (tx_state == TX_IDLE) || tx_end_c;

  // Echo transmitter with a one-entry holding buffer; back-to-back frames have no idle gap.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state   <= TX_IDLE;
      uart_txd_o <= 1'b1;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= '1;
      buf_valid  <= 1'b0;
      buf_data   <= '0;
    end else if (tx_free_c && (buf_valid || rx_fire_c)) begin
      tx_state   <= TX_RUN;
      uart_txd_o <= 1'b0;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_shift   <= {1'b1, (buf_valid ? buf_data : rx_shift)};
      if (buf_valid && rx_fire_c) buf_data  <= rx_shift;
      else                        buf_valid <= 1'b0;
    end else begin
      if (rx_fire_c) begin
        buf_data  <= rx_shift;
        buf_valid <= 1'b1;
      end
      if (tx_end_c) begin
        tx_state   <= TX_IDLE;
        uart_txd_o <= 1'b1;
      end else if (tx_state == TX_RUN) begin
        if (tx_cnt == BAUD_W'(BAUD_DIV - 1)) begin
          tx_cnt     <= '0;
          tx_bit     <= tx_bit + 4'd1;
          uart_txd_o <= tx_shift[0];
          tx_shift   <= {1'b1, tx_shift[8:1]};
        end else begin
          tx_cnt <= tx_cnt + BAUD_W'(1);
        end
      end
    end
  end

  // Nibble shown on the currently scanned digit.
  always_comb begin
    nib_c = '0;
    case (dig)
      3'd0: nib_c = sw_s[3:0];
      3'd1: nib_c = sw_s[7:4];
      3'd2: nib_c = sw_s[11:8];
      3'd3: nib_c = sw_s[15:12];
      3'd4: nib_c = uart_code[3:0];
      3'd5: nib_c = uart_code[7:4];
      3'd6: nib_c = ps2_code[3:0];
      3'd7: nib_c = ps2_code[7:4];
      default: nib_c = '0;
    endcase
  end

  // Digit scan; anode and cathode registered from the same digit index.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dig_cnt       <= '0;
      dig           <= '0;
      dsp_anode_o   <= 8'hFE;
      dsp_cathode_o <= 8'hFF;
    end else begin
      if (dig_cnt == DIG_W'(DIGIT_CYCLES - 1)) begin
        dig_cnt <= '0;
        dig     <= dig + 3'd1;
      end else begin
        dig_cnt <= dig_cnt + DIG_W'(1);
      end
      dsp_anode_o   <= ~(8'd1 << dig);
      dsp_cathode_o <= {1'b1, ~hex_seg(nib_c)};
    end
  end

  // VGA 640x480 timing counters advanced on every pixel tick.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pix_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      pix_cnt <= pix_cnt + 2'd1;
      if (pix_cnt == 2'(PIX_DIV - 1)) begin
        if (h_cnt == 10'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // Registered syncs and pixel colour.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vga_hsync_o <= 1'b1;
      vga_vsync_o <= 1'b1;
      vga_red_o   <= '0;
      vga_green_o <= '0;
      vga_blue_o  <= '0;
    end else begin
      vga_hsync_o <= !((h_cnt >= 10'(H_VISIBLE + H_FRONT)) &&
                       (h_cnt <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
      vga_vsync_o <= !((v_cnt >= 10'(V_VISIBLE + V_FRONT)) &&
                       (v_cnt <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
      if ((h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE))) begin
        vga_red_o   <= sw_s[11:8] ^ ps2_code[3:0];
        vga_green_o <= sw_s[7:4]  ^ ps2_code[3:0];
        vga_blue_o  <= sw_s[3:0]  ^ ps2_code[3:0];
      end else begin
        vga_red_o   <= '0;
        vga_green_o <= '0;
        vga_blue_o  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed bench for top: PS/2 decode and errors, UART echo, display scan, VGA timing.
module tb_top;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic        ps2_clk;
  logic        ps2_data;
  logic        rxd;
  logic        txd;
  logic        halt;
  logic [7:0]  anode;
  logic [7:0]  cathode;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync;

  int checks   = 0;
  int failures = 0;

  // Segment bytes as driven on the cathode pins (dp off, active-low g..a).
  localparam logic [7:0] G0 = 8'hC0;
  localparam logic [7:0] G1 = 8'hF9;
  localparam logic [7:0] G3 = 8'hB0;
  localparam logic [7:0] G5 = 8'h92;
  localparam logic [7:0] G9 = 8'h90;
  localparam logic [7:0] GA = 8'h88;
  localparam logic [7:0] GC = 8'hC6;
  localparam logic [7:0] GF = 8'h8E;

  top #(.DIGIT_CYCLES(8)) dut (
    .sys_clk_i     (clk),
    .rst_n_i       (rst_n),
    .switch_i      (sw),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .uart_rxd_i    (rxd),
    .uart_txd_o    (txd),
    .halt_o        (halt),
    .dsp_anode_o   (anode),
    .dsp_cathode_o (cathode),
    .vga_red_o     (red),
    .vga_green_o   (green),
    .vga_blue_o    (blue),
    .vga_hsync_o   (hsync),
    .vga_vsync_o   (vsync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_send(input logic [7:0] d, input logic par, input int nbits);
    logic [10:0] f;
    f = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (100) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (100) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic uart_send(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (868) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic uart_cap(input int limit, output logic [9:0] bits, output int gap);
    gap = 0;
    while (txd !== 1'b0 && gap < limit) begin
      @(negedge clk);
      gap++;
    end
    if (txd !== 1'b0) begin
      bits = 'x;
    end else begin
      repeat (434) @(negedge clk);
      bits[0] = txd;
      for (int i = 1; i < 10; i++) begin
        repeat (868) @(negedge clk);
        bits[i] = txd;
      end
    end
  endtask

  task automatic chk_dig(input string tag, input int d, input logic [7:0] exp);
    logic [7:0] want;
    logic [7:0] c;
    want = ~(8'd1 << d);
    c = 'x;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (anode === want) begin
        c = cathode;
        break;
      end
    end
    chk(tag, 32'(c), 32'(exp));
  endtask

  // Checks colour during hsync (blank) and then early in the next visible line.
  task automatic chk_rgb(input string tag, input logic [11:0] exp);
    int n;
    n = 0;
    while (hsync !== 1'b0 && n < 3300) begin @(negedge clk); n++; end
    chk({tag, "_blank"}, 32'({red, green, blue}), 32'h0);
    n = 0;
    while (hsync !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    repeat (300) @(negedge clk);
    chk(tag, 32'({red, green, blue}), 32'(exp));
  endtask

  initial begin
    logic [9:0] b1, b2;
    int g1, g2, lows;

    clk = 1'b0; rst_n = 1'b0; sw = 16'h9999;
    ps2_clk = 1'b1; ps2_data = 1'b1; rxd = 1'b1;

    // Reset values.
    repeat (5) @(negedge clk);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_txd", 32'(txd), 32'h1);
    chk("rst_anode", 32'(anode), 32'hFE);
    chk("rst_hsync", 32'(hsync), 32'h1);
    chk("rst_vsync", 32'(vsync), 32'h1);
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    rst_n = 1'b1;

    // VGA with ps2_code=0 and switches 9999.
    repeat (20) @(negedge clk);
    chk("rgb_999", 32'({red, green, blue}), 32'h999);
    lows = 0;
    for (int i = 0; i < 3200; i++) begin
      @(negedge clk);
      if (hsync === 1'b0) lows++;
    end
    chk("hsync_low_cycles", 32'(lows), 32'd384);
    chk_dig("dig0_9", 0, G9);
    chk_dig("dig3_9", 3, G9);
    chk_dig("dig4_0", 4, G0);
    chk_dig("dig7_0", 7, G0);

    // Good PS/2 frame 0x33, odd parity bit 1.
    ps2_send(8'h33, 1'b1, 11);
    chk("ps2_33_halt", 32'(halt), 32'h0);
    chk_dig("ps2_33_d7", 7, G3);
    chk_dig("ps2_33_d6", 6, G3);
    chk_rgb("rgb_aaa", 12'hAAA);

    // Break code 0xF0 is a normal code.
    ps2_send(8'hF0, 1'b1, 11);
    chk_dig("ps2_f0_d7", 7, GF);
    chk_dig("ps2_f0_d6", 6, G0);

    // Stalled partial frame is dropped silently, next frame aligns.
    ps2_send(8'h55, 1'b0, 4);
    repeat (5200) @(negedge clk);
    ps2_send(8'h1C, 1'b0, 11);
    chk("ps2_to_halt", 32'(halt), 32'h0);
    chk_dig("ps2_1c_d7", 7, G1);
    chk_dig("ps2_1c_d6", 6, GC);
    chk_rgb("rgb_555", 12'h555);

    // Bad parity: sticky halt, code unchanged.
    ps2_send(8'h33, 1'b0, 11);
    chk("ps2_bad_halt", 32'(halt), 32'h1);
    chk_dig("ps2_bad_d7", 7, G1);
    chk_dig("ps2_bad_d6", 6, GC);
    repeat (1000) @(negedge clk);
    chk("ps2_halt_sticky", 32'(halt), 32'h1);

    // Reset in the middle of a frame, then a clean frame.
    ps2_send(8'h33, 1'b1, 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_halt", 32'(halt), 32'h0);
    chk("mid_rst_anode", 32'(anode), 32'hFE);
    chk("mid_rst_txd", 32'(txd), 32'h1);
    rst_n = 1'b1;
    chk_dig("mid_rst_d7", 7, G0);
    ps2_send(8'h33, 1'b1, 11);
    chk("post_rst_halt", 32'(halt), 32'h0);
    chk_dig("post_rst_d7", 7, G3);
    chk_dig("post_rst_d6", 6, G3);

    // Single UART byte echo.
    fork
      uart_send(8'h5A, 1'b1);
      uart_cap(20000, b1, g1);
    join
    chk("echo_5a", 32'(b1), 32'(10'b1010110100));
    chk_dig("uart_5a_d5", 5, G5);
    chk_dig("uart_5a_d4", 4, GA);

    // Back-to-back bytes echoed in order without extra gap.
    fork
      begin
        uart_send(8'h3C, 1'b1);
        uart_send(8'hA5, 1'b1);
      end
      begin
        uart_cap(20000, b1, g1);
        uart_cap(2000, b2, g2);
      end
    join
    chk("echo_3c", 32'(b1), 32'(10'b1001111000));
    chk("echo_a5", 32'(b2), 32'(10'b1101001010));
    chk("echo_gap_ok", 32'(g2 >= 430 && g2 <= 440), 32'h1);
    chk_dig("uart_a5_d5", 5, GA);
    chk_dig("uart_a5_d4", 4, G5);

    // Framing error on stop bit: no echo, code unchanged.
    uart_send(8'h77, 1'b0);
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("discard_no_tx", 32'(lows), 32'h0);
    chk_dig("discard_d5", 5, GA);
    chk_dig("discard_d4", 4, G5);
    chk("vsync_idle", 32'(vsync), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
